// File: rtl/sram_controller.sv
// MEM-stage data-memory controller: serves 32-bit loads/stores
// as two half-word accesses to an external 16-bit async SRAM.
module sram_controller #(
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int CW = $clog2(ACCESS_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;
  logic [1:0]      is_write;
  logic [16:0]     w_q;
  logic [31:0]     data_q;
  logic [31:0]     offset;
  logic [16:0]     w_in;
  logic            last;
  logic            req;
  logic            unused_bits;

  assign offset      = address - BASE_ADDR;
  assign w_in        = offset[18:2];
  assign unused_bits = ^{offset[31:19], offset[1:0]};
  assign last        = (cnt == LAST);
  assign req         = rd_en | wr_en;

  assign sram_ce_n = 1'b0;
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

  // is_write[1]: store, is_write[0]: load
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ready      = 1'b0;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_dq_oe = 1'b0;
    unique case (state)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_n = LOW;
          cnt_n   = '0;
        end
      end
      LOW, HIGH: begin
        sram_we_n  = ~(is_write[1] & ~last);
        sram_oe_n  = ~is_write[0];
        sram_dq_oe = is_write[1];
        if (last) begin
          cnt_n   = '0;
          state_n = (state == LOW) ? HIGH : DONE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      is_write    <= '0;
      w_q         <= '0;
      data_q      <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == IDLE && req) begin
        w_q         <= w_in;
        data_q      <= write_data;
        is_write    <= {wr_en, rd_en & ~wr_en};
        sram_addr   <= {w_in, 1'b0};
        sram_dq_out <= write_data[15:0];
      end
      // address/data switch only after WE has risen
      if (state == LOW && last) begin
        sram_addr   <= {w_q, 1'b1};
        sram_dq_out <= data_q[31:16];
        if (is_write[0]) read_data[15:0] <= sram_dq_in;
      end
      if (state == HIGH && last && is_write[0])
        read_data[31:16] <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a
// behavioural async SRAM model.
module tb_sram_controller;

  logic        CLK;
  logic        RST;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        sram_ce_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  int total;
  int bad;

  logic [15:0] mem [0:255];

  sram_controller dut (
    .CLK        (CLK),
    .RST        (RST),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n),
    .sram_ce_n  (sram_ce_n),
    .sram_ub_n  (sram_ub_n),
    .sram_lb_n  (sram_lb_n)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: write while WE low, read while OE low
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    forever begin
      @(negedge CLK);
      if (!sram_we_n && sram_dq_oe)
        mem[sram_addr[7:0]] = sram_dq_out;
    end
  end

  assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[7:0]];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Runs request cycles 0..5; returns in the DONE cycle.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [17:0] hw);
    tick();
    rd_en = rd;
    wr_en = wr;
    address = a;
    write_data = d;
    #1;
    check("ready_c0", {31'd0, ready}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) begin
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = 32'd0;
        write_data = $urandom;
      end
      #1;
      check("ready_busy", {31'd0, ready}, 32'd0);
      check("addr", {14'd0, sram_addr},
            {14'd0, hw + ((c > 2) ? 18'd1 : 18'd0)});
      check("we_n", {31'd0, sram_we_n},
            {31'd0, ~wr | (c % 2 == 0)});
      check("oe_n", {31'd0, sram_oe_n}, {31'd0, wr});
      check("dq_oe", {31'd0, sram_dq_oe}, {31'd0, wr});
      if (wr)
        check("dq_out", {16'd0, sram_dq_out},
              {16'd0, (c > 2) ? d[31:16] : d[15:0]});
    end
    tick();
    check("ready_done", {31'd0, ready}, 32'd1);
    check("we_n_done", {31'd0, sram_we_n}, 32'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    RST = 1'b1;
    rd_en = 1'b0;
    wr_en = 1'b0;
    address = 32'd0;
    write_data = 32'd0;
    tick();
    tick();
    check("rst_rdata", read_data, 32'd0);
    check("rst_addr", {14'd0, sram_addr}, 32'd0);
    check("rst_dq", {16'd0, sram_dq_out}, 32'd0);
    check("rst_strobes",
          {28'd0, ready, sram_we_n, sram_oe_n, sram_dq_oe},
          32'b1110);
    check("tied", {29'd0, sram_ce_n, sram_ub_n, sram_lb_n},
          32'd0);
    RST = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle",
            {28'd0, ready, sram_we_n, sram_oe_n, sram_dq_oe},
            32'b1110);
    end

    access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 18'd2);
    check("mem2", {16'd0, mem[2]}, 32'h0000BEEF);
    check("mem3", {16'd0, mem[3]}, 32'h0000DEAD);
    check("store_rdata", read_data, 32'd0);

    access(1'b1, 1'b0, 32'd1028, 32'h0BADF00D, 18'd2);
    check("load", read_data, 32'hDEADBEEF);
    tick();
    check("load_hold", read_data, 32'hDEADBEEF);
    check("idle_ready", {31'd0, ready}, 32'd1);

    access(1'b0, 1'b1, 32'd1032, 32'h12345678, 18'd4);
    check("b2b_store_rdata", read_data, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'd1032, 32'h0, 18'd4);
    check("b2b_load", read_data, 32'h12345678);

    access(1'b1, 1'b1, 32'd1024, 32'hA5A5A5A5, 18'd0);
    check("both_rdata", read_data, 32'h12345678);
    check("both_mem0", {16'd0, mem[0]}, 32'h0000A5A5);
    check("both_mem1", {16'd0, mem[1]}, 32'h0000A5A5);

    tick();
    wr_en = 1'b1;
    address = 32'd1036;
    write_data = 32'hFFFFFFFF;
    tick();
    wr_en = 1'b0;
    address = 32'd0;
    check("rstw_c1_we", {31'd0, sram_we_n}, 32'd0);
    tick();
    RST = 1'b1;
    tick();
    #1;
    check("rstw_we", {31'd0, sram_we_n}, 32'd1);
    check("rstw_ready", {31'd0, ready}, 32'd1);
    check("rstw_rdata", read_data, 32'd0);
    check("rstw_addr", {14'd0, sram_addr}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rstw_idle_we", {31'd0, sram_we_n}, 32'd1);
    end
    check("rstw_mem6", {16'd0, mem[6]}, 32'h0000FFFF);
    check("rstw_mem7", {16'd0, mem[7]}, 32'h00000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

MEM-stage data-memory controller. It consumes the memory request presented by the MEM pipeline register (read/write enables, ALU-computed address, store data) and serves it from an external 16-bit asynchronous SRAM as two half-word accesses. It deasserts `ready` while an access is in flight so hazard/freeze logic can stall the pipeline, and it returns 32-bit load data to the WB path.

## Interface
Parameters:
- `ACCESS_CYCLES`, default 2: cycles per half-word access; legal range is 2 or more.
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `rd_en` in 1: load request from the MEM register.
- `wr_en` in 1: store request from the MEM register.
- `address` in 32: byte address (ALU result).
- `write_data` in 32: store data.
- `read_data` out 32: last completed load word.
- `ready` out 1: 0 means freeze the pipeline.
- `sram_addr` out 18: SRAM half-word address.
- `sram_dq_out` out 16: write data driven to SRAM.
- `sram_dq_in` in 16: data read back from SRAM.
- `sram_dq_oe` out 1: 1 means the controller drives DQ.
- `sram_we_n` out 1: SRAM write enable, active-low.
- `sram_oe_n` out 1: SRAM output enable, active-low.
- `sram_ce_n`, `sram_ub_n`, `sram_lb_n` out 1 each: tied to 0.

## Operation
- States are IDLE, LOW, HIGH and DONE. A 2-bit `is_write` flag, a latched address and latched data are held as registers.
- Address mapping: `w = (address - BASE_ADDR) >> 2`, truncated to 17 bits.
  - Low half-word is at `{w,1'b0}`.
  - High half-word is at `{w,1'b1}`.
  - `address[1:0]` is ignored.
- In IDLE, when `rd_en | wr_en` is asserted:
  - Latch `w`, `write_data` and `is_write = wr_en`. If both enables are high, the write wins.
  - Move to LOW and clear `cnt` to 0.
- In LOW:
  - `sram_addr = {w,0}`.
  - `cnt` counts from 0 to `ACCESS_CYCLES-1`.
  - At `cnt == ACCESS_CYCLES-1`, a read captures `sram_dq_in` into `read_data[15:0]`.
  - The state then moves to HIGH with `cnt = 0`.
- In HIGH, the behaviour is the same as LOW, using `{w,1}` and `read_data[31:16]`. The state then moves to DONE.
- DONE lasts one cycle and then returns to IDLE unconditionally. The request is not re-sampled in DONE.
- Write strobes:
  - During LOW and HIGH of a write, `sram_dq_oe = 1`.
  - `sram_dq_out` carries the latched data `[15:0]` in LOW and `[31:16]` in HIGH.
  - `sram_we_n = 0` while `cnt < ACCESS_CYCLES-1` and 1 on the final cycle of each phase, so address and data hold past the rising edge of WE.
- Read strobes: during LOW and HIGH of a read, `sram_oe_n = 0` and `sram_dq_oe = 0`.
- Idle strobes: outside LOW and HIGH, `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`, and `sram_addr` holds its last value.
- `ready` is combinational: `ready = (state==DONE) | (state==IDLE & ~rd_en & ~wr_en)`.
- `read_data` changes only on read captures. A write never modifies it.

## Timing
- Reset values:
  - state IDLE, `cnt = 0`, `read_data = 0`.
  - `sram_addr = 0`, `sram_dq_out = 0`.
  - `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`.
  - `ready = ~(rd_en|wr_en)`.
- Latency: from request visible in IDLE at cycle 0, `ready` is first high in cycle `1+2*ACCESS_CYCLES`, which is cycle 5 by default.
  - Six request cycles total; the pipeline freezes for 5.
  - `read_data` is valid from the DONE cycle onward.
- Back-to-back requests: the next instruction's request is seen in IDLE one cycle after DONE. There is no bubble other than the IDLE cycle.
- Inputs may change after the IDLE cycle without effect, because all values are latched.
- Reset mid-operation (any state):
  - Next edge returns to IDLE with all reset values.
  - No partial write completes after that edge.
  - `read_data` clears to 0.
- Address wrap: `w` is truncated modulo 2^17. An address below `BASE_ADDR` wraps the same way and is not flagged.

## Test plan
- **Idle:** `rd_en=wr_en=0` for 5 cycles → `ready=1`, `sram_we_n=1`, `sram_oe_n=1`, `sram_dq_oe=0` throughout.
- **Store:** `wr_en=1`, `address=1028`, `write_data=0xDEADBEEF`, against a behavioural SRAM model → `ready=0` for 5 cycles and high in cycle 5.
  - Model holds 0xBEEF at half-word 2 and 0xDEAD at half-word 3.
  - `sram_we_n` pattern over cycles 1–4 is 0,1,0,1.
- **Load:** following the store, `rd_en=1`, `address=1028` → `read_data=0xDEADBEEF` in DONE (cycle 5), held after `rd_en` drops.
- **Back-to-back:** store 0x12345678 at 1032, then immediately load 1032 → second request's IDLE cycle is directly after the first DONE; `read_data=0x12345678` 6 cycles later.
- **Simultaneous enables:** `rd_en=wr_en=1` with `write_data=0xA5A5A5A5` at 1024 → write performed (`sram_we_n` toggles) and `read_data` unchanged.
- **Reset mid-write:** assert `RST` in cycle 2 of a write of 0xFFFFFFFF at 1036 → next cycle state is IDLE and `sram_we_n=1`; high half-word 7 in the model is untouched, and `read_data=0`.
